// File: rtl/imem_fetch_rom_pkg.sv
// Shared CPU definitions: instruction width, NOP encoding, base opcodes and
// the response-holding state type used by the fetch unit.
package cpu_pkg;

   localparam int INSTR_W = 32;

   // addi x0, x0, 0
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   // RV32 major opcodes (instr[6:0])
   localparam logic [6:0] I_IMM  = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] R_TYPE = 7'b0110011;

   // Response holding register: EMPTY means rsp_valid=0, FULL means rsp_valid=1
   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_e;

endpackage

// File: rtl/imem_fetch_rom_if.sv
// Fetch request/response bundle between the PC generator / decode stage
// (master) and the instruction memory (slave).
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. While
// rsp_valid=1 and rsp_ready=0 every rsp_* signal holds its value. flush
// forces req_ready low and drops any held response at the next edge.
// rsp_state mirrors the holding register's state for observation.
interface imem_fetch_rom_if
   import cpu_pkg::*;
#(
   parameter int FETCH_W = 2,
   parameter int PC_W    = 32
);
   logic                       req_valid;
   logic                       req_ready;
   logic [PC_W-1:0]            req_pc;
   logic                       flush;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [PC_W-1:0]            rsp_pc;
   logic [FETCH_W*INSTR_W-1:0] rsp_instr;
   logic [FETCH_W-1:0]         rsp_lane_valid;
   logic                       rsp_fault;
   rsp_state_e                 rsp_state;

   modport master (
      output req_valid, req_pc, flush, rsp_ready,
      input  req_ready, rsp_valid, rsp_pc, rsp_instr, rsp_lane_valid, rsp_fault, rsp_state
   );

   modport slave (
      input  req_valid, req_pc, flush, rsp_ready,
      output req_ready, rsp_valid, rsp_pc, rsp_instr, rsp_lane_valid, rsp_fault, rsp_state
   );
endinterface

// File: rtl/imem_fetch_rom_resp_reg.sv
// One-entry EMPTY/FULL response holding register with pass-through ready:
// accepts new data when empty or when the held entry is leaving this cycle.
module imem_resp_reg
   import cpu_pkg::*;
#(
   parameter int           W       = 8,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output rsp_state_e   state
);

   rsp_state_e state_next;
   logic       accept;

   // Ready decode and next state; flush wins over accept and drain
   always_comb begin
      state_next = state;
      in_ready   = !flush && ((state == RSP_EMPTY) || out_ready);
      accept     = in_valid && in_ready;
      if (flush) begin
         state_next = RSP_EMPTY;
      end else if (accept) begin
         state_next = RSP_FULL;
      end else if ((state == RSP_FULL) && out_ready) begin
         state_next = RSP_EMPTY;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= RSP_EMPTY;
      else     state <= state_next;
   end

   // Payload captured only on accept so it holds under back-pressure
   always_ff @(posedge clk) begin
      if (rst)         out_data <= RST_VAL;
      else if (accept) out_data <= in_data;
   end

   assign out_valid = (state == RSP_FULL);

endmodule

// File: rtl/imem_fetch_rom.sv
// Multi-issue instruction ROM: returns FETCH_W consecutive words starting at
// a byte PC, one cycle after acceptance, with per-lane validity at the end of
// memory and a fault for misaligned or out-of-range PCs.
// Optional macro IMEM_WRITE_PORT_EN adds a read-first synchronous write port.
module imem_fetch_rom
  import cpu_pkg::*;
#(
  parameter int                 FETCH_W   = 2,
  parameter int                 DEPTH     = 1024,
  parameter int                 PC_W      = 32,
  parameter string              INIT_FILE = "",
  parameter logic [INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef IMEM_WRITE_PORT_EN
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [INSTR_W-1:0]         wr_data,
`endif
  imem_fetch_rom_if.slave            bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PW     = PC_W + FETCH_W*INSTR_W + FETCH_W + 1;
  localparam logic [PW-1:0] RSP_RST =
    {{PC_W{1'b0}}, {FETCH_W{NOP_INSTR}}, {FETCH_W{1'b0}}, 1'b0};

  logic [INSTR_W-1:0]         mem [DEPTH];
  logic [ADDR_W-1:0]          idx;
  logic                       fault;
  logic [FETCH_W-1:0]         lane_valid;
  logic [FETCH_W*INSTR_W-1:0] lane_instr;
  logic [PW-1:0]              rsp_data;

  // Memory image: NOP filler
  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = NOP_INSTR;
  end

`ifdef IMEM_WRITE_PORT_EN
  // Write port; not gated by rst, and the fetch path sees old data this cycle
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
`endif

  assign idx   = bus.req_pc[ADDR_W+1:2];
  assign fault = (bus.req_pc[1:0] != 2'b00) || (bus.req_pc[PC_W-1:ADDR_W+2] != '0);

  // Lane i reads word idx+i; the extra address bit flags running off the end
  for (genvar i = 0; i < FETCH_W; i++) begin : g_lane
    logic [ADDR_W:0] addr;
    assign addr          = {1'b0, idx} + (ADDR_W+1)'(i);
    assign lane_valid[i] = !addr[ADDR_W] && !fault;
    assign lane_instr[INSTR_W*i +: INSTR_W] =
      lane_valid[i] ? mem[addr[ADDR_W-1:0]] : NOP_INSTR;
  end

  imem_resp_reg #(
    .W       (PW),
    .RST_VAL (RSP_RST)
  ) u_resp (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .in_valid  (bus.req_valid),
    .in_ready  (bus.req_ready),
    .in_data   ({bus.req_pc, lane_instr, lane_valid, fault}),
    .out_valid (bus.rsp_valid),
    .out_ready (bus.rsp_ready),
    .out_data  (rsp_data),
    .state     (bus.rsp_state)
  );

  assign {bus.rsp_pc, bus.rsp_instr, bus.rsp_lane_valid, bus.rsp_fault} = rsp_data;

endmodule
